// File: rtl/stopwatch_control.sv
// Stopwatch control: button edge detection, RUN/PAUSED state and BCD mm:ss count.
// In adjust mode the selected field advances at 2 Hz instead of counting time.
module stopwatch_control (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       reset_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [1:0] adj_field
);

    localparam int unsigned DW = 4;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_pause_prev;
    logic          r_reset_prev;
    logic          w_pause_rise;
    logic          w_reset_rise;
    logic [DW-1:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [DW-1:0] w_min_tens_nx, w_min_ones_nx, w_sec_tens_nx, w_sec_ones_nx;
    logic [2*DW-1:0] w_sec_inc;
    logic [2*DW-1:0] w_min_inc;
    logic          w_sec_wrap;

    // Two-digit BCD increment, 59 wraps to 00; returns {tens, ones}
    function automatic logic [2*DW-1:0] bcd_inc(input logic [DW-1:0] tens,
                                                 input logic [DW-1:0] ones);
        if (ones != DW'(9))
            return {tens, DW'(ones + DW'(1))};
        else if (tens != DW'(5))
            return {DW'(tens + DW'(1)), DW'(0)};
        else
            return {DW'(0), DW'(0)};
    endfunction

    assign w_pause_rise = pause_btn & ~r_pause_prev;
    assign w_reset_rise = reset_btn & ~r_reset_prev;
    assign w_sec_inc    = bcd_inc(r_sec_tens, r_sec_ones);
    assign w_min_inc    = bcd_inc(r_min_tens, r_min_ones);
    assign w_sec_wrap   = (r_sec_tens == DW'(5)) && (r_sec_ones == DW'(9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PAUSED;
            r_pause_prev <= 1'b0;
            r_reset_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pause_prev <= pause_btn;
            r_reset_prev <= reset_btn;
        end
    end

    // Pause toggles the stored state even in adjust mode; reset event wins
    always_comb begin
        w_state_nx = r_state;
        if (w_reset_rise)
            w_state_nx = PAUSED;
        else if (w_pause_rise)
            w_state_nx = (r_state == RUN) ? PAUSED : RUN;
    end

    always_comb begin
        w_min_tens_nx = r_min_tens;
        w_min_ones_nx = r_min_ones;
        w_sec_tens_nx = r_sec_tens;
        w_sec_ones_nx = r_sec_ones;
        if (w_reset_rise) begin
            w_min_tens_nx = DW'(0);
            w_min_ones_nx = DW'(0);
            w_sec_tens_nx = DW'(0);
            w_sec_ones_nx = DW'(0);
        end else if (adj) begin
            if (tick_2hz) begin
                if (sel)
                    {w_sec_tens_nx, w_sec_ones_nx} = w_sec_inc;
                else
                    {w_min_tens_nx, w_min_ones_nx} = w_min_inc;
            end
        end else if ((r_state == RUN) && tick_1hz) begin
            {w_sec_tens_nx, w_sec_ones_nx} = w_sec_inc;
            if (w_sec_wrap)
                {w_min_tens_nx, w_min_ones_nx} = w_min_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_tens <= DW'(0);
            r_min_ones <= DW'(0);
            r_sec_tens <= DW'(0);
            r_sec_ones <= DW'(0);
        end else begin
            r_min_tens <= w_min_tens_nx;
            r_min_ones <= w_min_ones_nx;
            r_sec_tens <= w_sec_tens_nx;
            r_sec_ones <= w_sec_ones_nx;
        end
    end

    assign min_tens  = r_min_tens;
    assign min_ones  = r_min_ones;
    assign sec_tens  = r_sec_tens;
    assign sec_ones  = r_sec_ones;
    assign running   = (r_state == RUN) && !adj;
    assign adj_field = !adj ? 2'b00 : (sel ? 2'b01 : 2'b10);

endmodule

// File: tb/tb_stopwatch_control.sv
// Scoreboard bench for stopwatch_control: stimulus pushes expected display/status,
// a monitor pops and compares on the following falling edge.
module tb_stopwatch_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_btn, reset_btn, adj, sel, tick_1hz, tick_2hz;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [1:0] adj_field;

    logic lv_p, lv_r, lv_a, lv_s;

    typedef struct {
        string       nm;
        logic [18:0] v;   // {mm:ss BCD, running, adj_field}
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    stopwatch_control dut (
        .clk       (clk),
        .rst       (rst),
        .pause_btn (pause_btn),
        .reset_btn (reset_btn),
        .adj       (adj),
        .sel       (sel),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .adj_field (adj_field)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [18:0] got;
            e   = q.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones, running, adj_field};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %h%h:%h%h run=%b af=%b, expected %h%h:%h%h run=%b af=%b",
                         e.nm, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1:0],
                         e.v[18:15], e.v[14:11], e.v[10:7], e.v[6:3], e.v[2], e.v[1:0]);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [15:0] mmss,
                              input logic run, input logic [1:0] af);
        exp_t e;
        e.nm = nm;
        e.v  = {mmss, run, af};
        q.push_back(e);
    endtask

    task automatic cyc(input logic t1, input logic t2);
        @(negedge clk);
        #1;
        pause_btn = lv_p;
        reset_btn = lv_r;
        adj       = lv_a;
        sel       = lv_s;
        tick_1hz  = t1;
        tick_2hz  = t2;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
    endtask

    task automatic t1_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic t2_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lv_p = 0; lv_r = 0; lv_a = 0; lv_s = 0;
        pause_btn = 0; reset_btn = 0; adj = 0; sel = 0; tick_1hz = 0; tick_2hz = 0;
        cyc(1'b1, 1'b0);
        expect_out("reset_state", 16'h0000, 1'b0, 2'b00);
        @(negedge clk);
        #1 rst = 1'b0;

        // Start and count 61 seconds
        lv_p = 1; cyc(1'b0, 1'b0);
        expect_out("run_on", 16'h0000, 1'b1, 2'b00);
        lv_p = 0;
        t1_pulses(9);  expect_out("count_9", 16'h0009, 1'b1, 2'b00);
        t1_pulses(1);  expect_out("count_10", 16'h0010, 1'b1, 2'b00);
        t1_pulses(50); expect_out("count_60", 16'h0100, 1'b1, 2'b00);
        t1_pulses(1);  expect_out("count_61", 16'h0101, 1'b1, 2'b00);

        // Reset button clears and pauses
        lv_r = 1; cyc(1'b0, 1'b0);
        expect_out("reset_btn", 16'h0000, 1'b0, 2'b00);
        lv_r = 0; cyc(1'b0, 1'b0);

        // Preload 59:58 via adjust, including minute-field wrap
        lv_a = 1; lv_s = 0;
        t2_pulses(59); expect_out("adj_min_59", 16'h5900, 1'b0, 2'b10);
        t2_pulses(1);  expect_out("adj_min_wrap", 16'h0000, 1'b0, 2'b10);
        t2_pulses(59); expect_out("adj_min_59b", 16'h5900, 1'b0, 2'b10);
        lv_s = 1;
        t2_pulses(58); expect_out("adj_sec_58", 16'h5958, 1'b0, 2'b01);
        lv_a = 0; cyc(1'b0, 1'b0);
        expect_out("adj_exit", 16'h5958, 1'b0, 2'b00);
        lv_p = 1; cyc(1'b0, 1'b0);
        expect_out("run_5958", 16'h5958, 1'b1, 2'b00);
        lv_p = 0;
        t1_pulses(1); expect_out("to_5959", 16'h5959, 1'b1, 2'b00);
        t1_pulses(1); expect_out("wrap_0000", 16'h0000, 1'b1, 2'b00);

        // Pause, tick while paused is ignored
        lv_p = 1; cyc(1'b0, 1'b0);
        expect_out("pause", 16'h0000, 1'b0, 2'b00);
        lv_p = 0;
        t1_pulses(1); expect_out("paused_tick", 16'h0000, 1'b0, 2'b00);

        // Held pause button toggles once; three ticks counted
        lv_p = 1;
        for (int i = 0; i < 1000; i++) begin
            cyc((i == 100) || (i == 500) || (i == 900), 1'b0);
            if (i == 0) expect_out("hold_first", 16'h0000, 1'b1, 2'b00);
        end
        expect_out("hold_end", 16'h0003, 1'b1, 2'b00);
        lv_p = 0; cyc(1'b0, 1'b0);
        expect_out("hold_release", 16'h0003, 1'b1, 2'b00);

        // Reach 00:12 then coincident pause+reset+tick
        t1_pulses(9); expect_out("at_0012", 16'h0012, 1'b1, 2'b00);
        lv_p = 1; lv_r = 1; cyc(1'b1, 1'b0);
        expect_out("reset_over_all", 16'h0000, 1'b0, 2'b00);
        lv_p = 0; lv_r = 0;
        t1_pulses(1); expect_out("still_paused", 16'h0000, 1'b0, 2'b00);

        // Adjust seconds wrap with interleaved 1 Hz ticks; minutes preserved
        lv_a = 1; lv_s = 0;
        t2_pulses(7); expect_out("adj_min_07", 16'h0700, 1'b0, 2'b10);
        lv_s = 1;
        t2_pulses(58); expect_out("adj_sec_58b", 16'h0758, 1'b0, 2'b01);
        t2_pulses(1); expect_out("adj_sec_59", 16'h0759, 1'b0, 2'b01);
        t1_pulses(1); expect_out("adj_ign_1hz", 16'h0759, 1'b0, 2'b01);
        t2_pulses(1); expect_out("adj_sec_00", 16'h0700, 1'b0, 2'b01);
        t1_pulses(1);
        t2_pulses(1); expect_out("adj_sec_01", 16'h0701, 1'b0, 2'b01);

        // Pause toggle during adjust takes effect on exit
        lv_p = 1; cyc(1'b0, 1'b0);
        expect_out("adj_pause", 16'h0701, 1'b0, 2'b01);
        lv_p = 0;
        t1_pulses(1); expect_out("adj_run_ign", 16'h0701, 1'b0, 2'b01);
        lv_a = 0; cyc(1'b0, 1'b0);
        expect_out("adj_exit_run", 16'h0701, 1'b1, 2'b00);
        t2_pulses(1); expect_out("norm_ign_2hz", 16'h0701, 1'b1, 2'b00);
        t1_pulses(1); expect_out("norm_0702", 16'h0702, 1'b1, 2'b00);

        // Set 12:34 and apply asynchronous reset between edges
        lv_a = 1; lv_s = 0;
        t2_pulses(5);
        lv_s = 1;
        t2_pulses(32); expect_out("adj_1234", 16'h1234, 1'b0, 2'b01);
        lv_a = 0; cyc(1'b0, 1'b0);
        expect_out("run_1234", 16'h1234, 1'b1, 2'b00);
        lv_p = 1;
        @(posedge clk);
        #2 rst = 1'b1;
        expect_out("async_rst", 16'h0000, 1'b0, 2'b00);
        cyc(1'b1, 1'b0);
        expect_out("rst_held", 16'h0000, 1'b0, 2'b00);
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0);
        expect_out("held_btn_after_rst", 16'h0000, 1'b1, 2'b00);
        cyc(1'b0, 1'b0);
        expect_out("held_no_retoggle", 16'h0000, 1'b1, 2'b00);
        lv_p = 0; cyc(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
